// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor controller, optional saturation via SERIAL_SUB_SAT_EN
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_nxt;
    logic             d;
    logic             hs1_d;
    logic             hs1_b;
    logic             hs2_b;
    logic             last;

    // Two half-subtractor stages chained through the borrow register
    always_comb begin
        hs1_d  = a_sh[0] ^ b_sh[0];
        hs1_b  = ~a_sh[0] & b_sh[0];
        d      = hs1_d ^ br;
        hs2_b  = ~hs1_d & br;
        br_nxt = hs1_b | hs2_b;
        last   = (cnt == CW'(WIDTH - 1));
        // Result fills from the MSB end so the LSB-first bits settle in place
        res_nxt            = res >> 1;
        res_nxt[WIDTH-1]   = d;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff <= br_nxt ? '0 : res_nxt;
`else
                        diff <= res_nxt;
`endif
                        borrow <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed-vector bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_sub_ctrl;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] last_d  = 8'h00;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb);
        int         n;
        logic [7:0] want;
        want = (SAT && eb) ? 8'h00 : ed;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            chk("hold_diff", diff, last_d);
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 8);
        chk("done", done, 1);
        chk("diff", diff, want);
        chk("borrow", borrow, eb);
        @(negedge clk);
        chk("done_clr", done, 0);
        chk("busy_idle", busy, 0);
        last_d = want;
    endtask

    initial begin
        int n;
        int dones;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        rst = 1'b0;

        do_op(8'h05, 8'h03, 8'h02, 1'b0);
        do_op(8'h03, 8'h05, 8'hFE, 1'b1);
        do_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        do_op(8'h00, 8'h01, 8'hFF, 1'b1);
        do_op(8'hA5, 8'h5A, 8'h4B, 1'b0);
        do_op(8'h00, 8'h80, 8'h80, 1'b1);

        // start re-pulsed in RUN and DONE: one done only, then IDLE start accepted
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            start = (n == 2);
            if (n == 3) begin a = 8'h00; b = 8'hFF; end
            n++;
            @(negedge clk);
        end
        dones += (done === 1'b1);
        chk("repulse_diff", diff, 8'h0F);
        start = 1'b1;
        a = 8'h09; b = 8'h04;
        @(negedge clk);
        chk("done_in_idle", done, 0);
        chk("busy_in_idle", busy, 0);
        @(negedge clk);
        start = 1'b0;
        chk("idle_start_acc", busy, 1);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("one_done_pulse", dones, 1);
        chk("second_done", done, 1);
        chk("second_diff", diff, 8'h05);
        @(negedge clk);

        // reset in the 4th RUN cycle aborts with no done
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            dones += (done === 1'b1);
        end
        chk("abort_no_done", dones, 0);

        // WIDTH=1 instance
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        @(negedge clk);
        chk("w1_done", done1, 1);
        chk("w1_diff", diff1, SAT ? 1'b0 : 1'b1);
        chk("w1_borrow", borrow1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; the legal range SHALL be 1 to 32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  SHALL be the request to begin one subtraction, sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  SHALL be the minuend, captured when start is accepted.
REQ-006 b  input  WIDTH  SHALL be the subtrahend, captured when start is accepted.
REQ-007 busy  output  1  SHALL be high while the bit-serial operation is in progress.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-009 diff  output  WIDTH  SHALL be the registered difference result.
REQ-010 borrow  output  1  SHALL be the registered final borrow-out.

Function
REQ-011 The block SHALL sequence a single one-bit subtract cell, built from two half-subtractor stages plus a borrow register, over the operand bits LSB first, one bit per clock.
REQ-012 Bit rule SHALL be: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a and b into shift registers, clear br and the bit counter, and enter RUN.
REQ-015 RUN: each edge SHALL process bit counter, shift d into an internal result register and increment the counter; after the WIDTH-th bit the FSM SHALL enter DONE.
REQ-016 On entering DONE, diff and borrow SHALL update from the internal result and final br; done SHALL be 1 for exactly that one cycle; the next edge SHALL return the FSM to IDLE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high from edge k+WIDTH+1 to edge k+WIDTH+2.
REQ-018 busy SHALL equal 1 exactly while the state is RUN.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing; a and b changes after acceptance SHALL have no effect.
REQ-020 diff and borrow SHALL hold the last completed result through IDLE and RUN until the next DONE.
REQ-021 Without saturation, the result SHALL equal diff = (a - b) mod 2^WIDTH and borrow = (a < b), unsigned.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borrow=0, br=0 and counter=0, regardless of state.
REQ-023 Reset mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-024 Macro SERIAL_SUB_SAT_EN defined: on entering DONE with final br=1, diff SHALL be forced to 0 and borrow SHALL be 1.
REQ-025 Macro SERIAL_SUB_SAT_EN undefined: diff SHALL be the modulo result per REQ-021; no saturation logic SHALL be present.

Verification
REQ-026 WIDTH=8, a=0x05, b=0x03, start pulsed at edge 0 -> busy for 8 cycles; at edge 9 done=1, diff=0x02, borrow=0.
REQ-027 a=0x03, b=0x05 -> diff=0xFE, borrow=1; with SERIAL_SUB_SAT_EN defined -> diff=0x00, borrow=1.
REQ-028 a=0xFF, b=0xFF, then a=0x00, b=0x01 -> first result diff=0x00, borrow=0; second diff=0xFF, borrow=1; diff holds 0x00 during the second RUN.
REQ-029 start re-pulsed during RUN and during DONE -> ignored: one done pulse only; start in the following IDLE cycle is accepted.
REQ-030 rst asserted at the 4th RUN cycle of a=0x80, b=0x01 -> next cycle IDLE, busy=0, diff=0, borrow=0, no done pulse.
REQ-031 WIDTH=1: a=0, b=1 -> done at edge 2, diff=1, borrow=1.
